cache_arbiter: RTL and testbench

//  Shares one 256-bit physical-memory port between the instruction-side and data-side L1 caches.

---
 rtl/cache_arb_pkg.sv | 10 +
 rtl/cache_arbiter.sv | 124 ++++++++++++
 tb/tb_cache_arbiter.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_arb_pkg.sv
// Shared types and sizes for the cache arbiter.
package cache_arb_pkg;

   localparam int S_ADDR = 32;
   localparam int S_LINE = 256;

   typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, DONE} arb_state_t;
   typedef enum logic {ICACHE, DCACHE} requester_t;

endpackage

// File: rtl/cache_arbiter.sv
// Shares one line-wide physical-memory port between the I-side and D-side L1
// caches. One transaction at a time, round-robin on conflict, one DONE bubble
// after every completion so the served cache can drop its request.
//
// Handshake: each cache raises read or write and holds it, with address and
// data, until it sees its one-cycle resp pulse. Downstream, pmem_read/write
// are held until the one-cycle pmem_resp; rdata is only meaningful with resp.
module cache_arbiter
   import cache_arb_pkg::*;
#(
   parameter int s_addr = S_ADDR,
   parameter int s_line = S_LINE
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              icache_pmem_read,
   input  logic              icache_pmem_write,
   input  logic [s_addr-1:0] icache_pmem_address,
   input  logic [s_line-1:0] icache_pmem_wdata,
   output logic              icache_pmem_resp,
   output logic [s_line-1:0] icache_pmem_rdata,
   input  logic              dcache_pmem_read,
   input  logic              dcache_pmem_write,
   input  logic [s_addr-1:0] dcache_pmem_address,
   input  logic [s_line-1:0] dcache_pmem_wdata,
   output logic              dcache_pmem_resp,
   output logic [s_line-1:0] dcache_pmem_rdata,
   output logic              pmem_read,
   output logic              pmem_write,
   output logic [s_addr-1:0] pmem_address,
   output logic [s_line-1:0] pmem_wdata,
   input  logic              pmem_resp,
   input  logic [s_line-1:0] pmem_rdata
);

   arb_state_t state, next_state;
   requester_t last_grant, next_grant;
   logic       i_pending, d_pending;

   assign i_pending = icache_pmem_read | icache_pmem_write;
   assign d_pending = dcache_pmem_read | dcache_pmem_write;

   // State register and round-robin pointer; reset parks the pointer on D so I wins first.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         last_grant <= DCACHE;
      end else begin
         state      <= next_state;
         last_grant <= next_grant;
      end
   end

   // Next-state: grant from IDLE only, the pointer records whoever was granted last.
   always_comb begin
      next_state = state;
      next_grant = last_grant;
      case (state)
         IDLE: begin
            if (i_pending && d_pending) begin
               if (last_grant == DCACHE) begin
                  next_state = SERVE_I;
                  next_grant = ICACHE;
               end else begin
                  next_state = SERVE_D;
                  next_grant = DCACHE;
               end
            end else if (i_pending) begin
               next_state = SERVE_I;
               next_grant = ICACHE;
            end else if (d_pending) begin
               next_state = SERVE_D;
               next_grant = DCACHE;
            end
         end
         SERVE_I: if (pmem_resp) next_state = DONE;
         SERVE_D: if (pmem_resp) next_state = DONE;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Output mux: downstream request follows the granted side's live inputs; write wins over read.
   always_comb begin
      pmem_read         = 1'b0;
      pmem_write        = 1'b0;
      pmem_address      = '0;
      pmem_wdata        = '0;
      icache_pmem_resp  = 1'b0;
      icache_pmem_rdata = '0;
      dcache_pmem_resp  = 1'b0;
      dcache_pmem_rdata = '0;
      case (state)
         SERVE_I: begin
            pmem_write        = icache_pmem_write;
            pmem_read         = icache_pmem_read & ~icache_pmem_write;
            pmem_address      = icache_pmem_address;
            pmem_wdata        = icache_pmem_wdata;
            icache_pmem_resp  = pmem_resp;
            icache_pmem_rdata = pmem_resp ? pmem_rdata : '0;
         end
         SERVE_D: begin
            pmem_write        = dcache_pmem_write;
            pmem_read         = dcache_pmem_read & ~dcache_pmem_write;
            pmem_address      = dcache_pmem_address;
            pmem_wdata        = dcache_pmem_wdata;
            dcache_pmem_resp  = pmem_resp;
            dcache_pmem_rdata = pmem_resp ? pmem_rdata : '0;
         end
         default: ;
      endcase
   end

   // Protocol checks: no read+write together, no request dropped while being served.
   always @(posedge clk) begin
      if (rst_n) begin
         assert (!(icache_pmem_read && icache_pmem_write));
         assert (!(dcache_pmem_read && dcache_pmem_write));
         if (state == SERVE_I) assert (i_pending);
         if (state == SERVE_D) assert (d_pending);
      end
   end

endmodule

// File: tb/tb_cache_arbiter.sv
// Randomized scoreboard bench for cache_arbiter: a transaction-level model
// predicts grant order and line contents; a monitor checks the DUT against it.
module tb_cache_arbiter;
   import cache_arb_pkg::*;

   localparam int AW = 32;
   localparam int LW = 256;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          icache_pmem_read, icache_pmem_write;
   logic [AW-1:0] icache_pmem_address;
   logic [LW-1:0] icache_pmem_wdata;
   logic          icache_pmem_resp;
   logic [LW-1:0] icache_pmem_rdata;
   logic          dcache_pmem_read, dcache_pmem_write;
   logic [AW-1:0] dcache_pmem_address;
   logic [LW-1:0] dcache_pmem_wdata;
   logic          dcache_pmem_resp;
   logic [LW-1:0] dcache_pmem_rdata;
   logic          pmem_read, pmem_write;
   logic [AW-1:0] pmem_address;
   logic [LW-1:0] pmem_wdata;
   logic          pmem_resp;
   logic [LW-1:0] pmem_rdata;

   cache_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .icache_pmem_read(icache_pmem_read), .icache_pmem_write(icache_pmem_write),
      .icache_pmem_address(icache_pmem_address), .icache_pmem_wdata(icache_pmem_wdata),
      .icache_pmem_resp(icache_pmem_resp), .icache_pmem_rdata(icache_pmem_rdata),
      .dcache_pmem_read(dcache_pmem_read), .dcache_pmem_write(dcache_pmem_write),
      .dcache_pmem_address(dcache_pmem_address), .dcache_pmem_wdata(dcache_pmem_wdata),
      .dcache_pmem_resp(dcache_pmem_resp), .dcache_pmem_rdata(dcache_pmem_rdata),
      .pmem_read(pmem_read), .pmem_write(pmem_write),
      .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
      .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish, required finish before 500000ns");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard state ----------------
   typedef struct {
      bit            side;     // 0 = I, 1 = D
      bit            wr;
      logic [AW-1:0] addr;
      logic [LW-1:0] wdata;
      int            start;    // expected cycle of downstream request, -1 = unchecked
      bit            chk_gap;  // expect re-grant 3 cycles after previous resp
   } req_t;
   typedef struct {
      bit            side;
      logic [LW-1:0] rdata;
   } rsp_t;

   req_t req_q[$];
   rsp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   logic [LW-1:0] mem       [logic [AW-1:0]];
   logic [LW-1:0] model_mem [logic [AW-1:0]];
   bit            model_last;

   function automatic logic [LW-1:0] dflt(input logic [AW-1:0] a);
      return {8{a ^ 32'h5A5A_5A5A}};
   endfunction

   task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @cyc %0d: got %h required %h", name, cyc, act, exp);
      end
   endtask

   // Reference model: one call per granted transaction, in grant order.
   task automatic model_txn(input bit side, input bit wr, input logic [AW-1:0] a,
                            input logic [LW-1:0] wd, input int start, input bit gap);
      rsp_t e;
      req_q.push_back('{side, wr, a, wd, start, gap});
      e.side = side;
      if (wr) begin
         e.rdata = '0;
         model_mem[a] = wd;
      end else begin
         e.rdata = model_mem.exists(a) ? model_mem[a] : dflt(a);
      end
      exp_q.push_back(e);
      model_last = side;
   endtask

   // ---------------- memory responder ----------------
   bit mem_auto = 1'b1;
   int delay_sel = -1;
   bit busy = 1'b0;
   int cnt = 0;

   initial begin
      pmem_resp  = 1'b0;
      pmem_rdata = '0;
      forever begin
         @(posedge clk);
         #2;
         if (mem_auto) begin
            pmem_resp  = 1'b0;
            pmem_rdata = {8{$urandom}};
            if (!rst_n) begin
               busy = 1'b0;
            end else if (pmem_read || pmem_write) begin
               if (!busy) begin
                  busy = 1'b1;
                  cnt  = (delay_sel < 0) ? int'($urandom_range(0, 3)) : delay_sel;
               end
               if (cnt == 0) begin
                  pmem_resp = 1'b1;
                  busy      = 1'b0;
                  if (pmem_write) begin
                     mem[pmem_address] = pmem_wdata;
                     pmem_rdata = '0;
                  end else begin
                     pmem_rdata = mem.exists(pmem_address) ? mem[pmem_address] : dflt(pmem_address);
                  end
               end else begin
                  cnt--;
               end
            end
         end
      end
   end

   // ---------------- monitor ----------------
   bit mon_en = 1'b0;
   bit req_prev = 1'b0;
   bit rsp_prev = 1'b0;
   int last_rsp_cyc = -100;

   always @(negedge clk) begin : mon
      logic req_now;
      req_t r;
      rsp_t e;
      if (!rst_n) begin
         req_prev = 1'b0;
         rsp_prev = 1'b0;
      end else if (mon_en) begin
         req_now = pmem_read | pmem_write;
         if (rsp_prev)
            check("done_bubble", {252'd0, pmem_read, pmem_write, icache_pmem_resp, dcache_pmem_resp}, '0);
         if (req_now && !req_prev) begin
            if (req_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_req @cyc %0d: got addr %h required no request", cyc, pmem_address);
            end else begin
               r = req_q.pop_front();
               check("req_op", {254'd0, pmem_write, pmem_read}, r.wr ? 256'd2 : 256'd1);
               check("req_addr", {224'd0, pmem_address}, {224'd0, r.addr});
               if (r.wr) check("req_wdata", pmem_wdata, r.wdata);
               if (r.start >= 0) check("req_lag", cyc, r.start);
               if (r.chk_gap) check("regrant_gap", cyc - last_rsp_cyc, 3);
            end
         end
         if (icache_pmem_resp || dcache_pmem_resp) begin
            check("single_resp", {255'd0, icache_pmem_resp & dcache_pmem_resp}, '0);
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_resp @cyc %0d: got i=%0b d=%0b required none",
                        cyc, icache_pmem_resp, dcache_pmem_resp);
            end else begin
               e = exp_q.pop_front();
               check("resp_side", {255'd0, dcache_pmem_resp}, {255'd0, e.side});
               check("resp_rdata", dcache_pmem_resp ? dcache_pmem_rdata : icache_pmem_rdata, e.rdata);
               check("other_rdata", dcache_pmem_resp ? icache_pmem_rdata : dcache_pmem_rdata, '0);
            end
            last_rsp_cyc = cyc;
         end else if (req_now) begin
            check("rdata_gated", icache_pmem_rdata | dcache_pmem_rdata, '0);
         end
         req_prev = req_now;
         rsp_prev = icache_pmem_resp | dcache_pmem_resp;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_i(input bit rd, input bit wr, input logic [AW-1:0] a, input logic [LW-1:0] wd);
      icache_pmem_read    = rd;
      icache_pmem_write   = wr;
      icache_pmem_address = a;
      icache_pmem_wdata   = wd;
   endtask

   task automatic set_d(input bit rd, input bit wr, input logic [AW-1:0] a, input logic [LW-1:0] wd);
      dcache_pmem_read    = rd;
      dcache_pmem_write   = wr;
      dcache_pmem_address = a;
      dcache_pmem_wdata   = wd;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      set_i(0, 0, '0, '0);
      set_d(0, 0, '0, '0);
      tick();
      tick();
      rst_n = 1'b1;
      model_last = 1'b1;
      req_q.delete();
      exp_q.delete();
   endtask

   task automatic check_quiet(input string tag);
      @(negedge clk);
      check({tag, "_ctl"}, {252'd0, icache_pmem_resp, dcache_pmem_resp, pmem_read, pmem_write}, '0);
      check({tag, "_addr"}, {224'd0, pmem_address}, '0);
      check({tag, "_wdata"}, pmem_wdata, '0);
      check({tag, "_rdata"}, icache_pmem_rdata | dcache_pmem_rdata, '0);
      tick();
   endtask

   // Each cache drops its request the cycle after seeing its resp pulse.
   task automatic wait_round(input bit need_i, input bit need_d);
      bit gi, gd, si, sd;
      int budget;
      gi = !need_i;
      gd = !need_d;
      budget = 200;
      while (!(gi && gd) && budget > 0) begin
         @(negedge clk);
         si = icache_pmem_resp;
         sd = dcache_pmem_resp;
         tick();
         if (si) begin gi = 1'b1; set_i(0, 0, '0, '0); end
         if (sd) begin gd = 1'b1; set_d(0, 0, '0, '0); end
         budget--;
      end
      if (!(gi && gd)) begin
         n_cmp++;
         n_bad++;
         $display("FAIL round_timeout: got i_done=%0b d_done=%0b required both", gi, gd);
         set_i(0, 0, '0, '0);
         set_d(0, 0, '0, '0);
      end
      tick();
   endtask

   // Issue one request per chosen side in the same IDLE cycle.
   task automatic round(input bit di, input bit wi, input logic [AW-1:0] ai, input logic [LW-1:0] wdi,
                        input bit dd, input bit wdw, input logic [AW-1:0] ad, input logic [LW-1:0] wdd);
      int st;
      st = cyc + 1;
      if (di && dd) begin
         if (!model_last) begin
            model_txn(1, wdw, ad, wdd, st, 0);
            model_txn(0, wi, ai, wdi, -1, 1);
         end else begin
            model_txn(0, wi, ai, wdi, st, 0);
            model_txn(1, wdw, ad, wdd, -1, 1);
         end
      end else if (di) begin
         model_txn(0, wi, ai, wdi, st, 0);
      end else if (dd) begin
         model_txn(1, wdw, ad, wdd, st, 0);
      end
      if (di) set_i(!wi, wi, ai, wdi);
      if (dd) set_d(!wdw, wdw, ad, wdd);
      wait_round(di, dd);
   endtask

   // Both caches request back to back; each re-requests during DONE.
   task automatic continuous();
      logic [AW-1:0] ia[3], da[3];
      bit            dw[3];
      logic [LW-1:0] dwd[3];
      int ci, cd, budget, k, st;
      bit first, side, si, sd;
      for (int j = 0; j < 3; j++) begin
         ia[j]  = 32'h300 + 32'(j * 32);
         da[j]  = 32'h400 + 32'(j * 32);
         dw[j]  = (j == 1);
         dwd[j] = {8{$urandom}};
      end
      st = cyc + 1;
      first = !model_last;
      for (k = 0; k < 6; k++) begin
         side = first ^ k[0];
         if (side) model_txn(1, dw[k/2], da[k/2], dwd[k/2], (k == 0) ? st : -1, k > 0);
         else      model_txn(0, 0, ia[k/2], '0, (k == 0) ? st : -1, k > 0);
      end
      set_i(1, 0, ia[0], '0);
      set_d(!dw[0], dw[0], da[0], dwd[0]);
      ci = 0;
      cd = 0;
      budget = 300;
      while (!(ci == 3 && cd == 3) && budget > 0) begin
         @(negedge clk);
         si = icache_pmem_resp;
         sd = dcache_pmem_resp;
         tick();
         if (si) begin
            ci++;
            if (ci < 3) set_i(1, 0, ia[ci], '0);
            else        set_i(0, 0, '0, '0);
         end
         if (sd) begin
            cd++;
            if (cd < 3) set_d(!dw[cd], dw[cd], da[cd], dwd[cd]);
            else        set_d(0, 0, '0, '0);
         end
         budget--;
      end
      if (!(ci == 3 && cd == 3)) begin
         n_cmp++;
         n_bad++;
         $display("FAIL continuous_timeout: got i=%0d d=%0d required 3 and 3", ci, cd);
         set_i(0, 0, '0, '0);
         set_d(0, 0, '0, '0);
      end
      tick();
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [LW-1:0] aa_line;
      logic [AW-1:0] ai, ad;
      bit            di, dd, wi, wd;
      bit            seen;

      do_reset();
      mon_en = 1'b1;
      check_quiet("reset");

      // Uncontended I read, memory answers after 3 cycles.
      aa_line = {32{8'hAA}};
      mem[32'h40] = aa_line;
      model_mem[32'h40] = aa_line;
      delay_sel = 3;
      round(1, 0, 32'h40, '0, 0, 0, '0, '0);

      // Simultaneous I read / D write right after reset: I first.
      do_reset();
      check_quiet("reset2");
      delay_sel = -1;
      round(1, 0, 32'h100, '0, 1, 1, 32'h200, {8{32'hC0FF_EE00}});

      // Continuous contention: I,D,I,D,I,D.
      do_reset();
      continuous();

      // Spurious pmem_resp in IDLE.
      mem_auto = 1'b0;
      pmem_resp = 1'b1;
      pmem_rdata = {8{32'hDEAD_BEEF}};
      check_quiet("spurious");
      pmem_resp = 1'b0;

      // Reset in the middle of a D read, then stale resp, then fresh I read.
      model_txn(1, 0, 32'h600, '0, cyc + 1, 0);
      set_d(1, 0, 32'h600, '0);
      seen = 1'b0;
      for (int j = 0; j < 10 && !seen; j++) begin
         @(negedge clk);
         seen = pmem_read;
      end
      check("midreset_req_seen", {255'd0, seen}, 256'd1);
      tick();
      rst_n = 1'b0;
      set_d(0, 0, '0, '0);
      tick();
      rst_n = 1'b1;
      model_last = 1'b1;
      req_q.delete();
      exp_q.delete();
      check_quiet("midreset");
      pmem_resp = 1'b1;
      pmem_rdata = {8{32'h1234_5678}};
      check_quiet("stale_resp");
      pmem_resp = 1'b0;
      mem_auto = 1'b1;
      round(1, 0, 32'h700, '0, 0, 0, '0, '0);

      // D read with one-cycle memory latency.
      delay_sel = 1;
      round(0, 0, '0, '0, 1, 0, 32'h800, '0);

      // Randomized rounds.
      delay_sel = -1;
      for (int n = 0; n < 40; n++) begin
         di = 1'($urandom_range(0, 1));
         dd = 1'($urandom_range(0, 1));
         if (!di && !dd) di = 1'b1;
         wi = 1'($urandom_range(0, 1));
         wd = 1'($urandom_range(0, 1));
         ai = {22'd0, 5'($urandom_range(0, 15)), 5'd0};
         ad = {22'd0, 5'($urandom_range(0, 15)), 5'd0};
         round(di, wi, ai, {8{$urandom}}, dd, wd, ad, {8{$urandom}});
      end

      tick();
      tick();
      mon_en = 1'b0;
      check("leftover_req", 256'(req_q.size()), '0);
      check("leftover_resp", 256'(exp_q.size()), '0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
